// File: rtl/qpsk_mimo_modulator.sv
// Serial bits -> four QPSK symbols -> y_hat = R*x with upper-triangular R, add/subtract only.
// Optional feature macro MOD_NOISE_EN: deterministic 4-bit LFSR noise added to each y_i.
module qpsk_mimo_modulator #(
    parameter int R_W = 16,
    parameter int Y_W = 20
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              i_r_load,
    input  logic [20*R_W-1:0] i_r,
    input  logic              i_bit_vld,
    input  logic              i_bit,
    output logic              o_bit_rdy,
    output logic              o_vld,
    input  logic              i_rdy,
    output logic [8*Y_W-1:0]  o_y_hat,
    output logic              o_busy
);

    typedef enum logic [1:0] {COLLECT, CALC, OUT} state_t;

    state_t              state, state_nxt;
    logic [2:0]          bit_cnt;
    logic [7:0]          bits;
    logic [20*R_W-1:0]   r_reg;
    logic [1:0]          row;
    logic                vld;
    logic                accept;
    logic                take;
    logic signed [Y_W-1:0] row_re, row_im;
    logic signed [Y_W-1:0] y_re, y_im;
    logic signed [R_W-1:0] ra, rb;
    logic signed [Y_W-1:0] a, b;
    int unsigned           k;

    assign accept    = (state == COLLECT) && i_bit_vld;
    assign take      = (state == OUT) && vld && i_rdy;
    assign o_vld     = vld;

    always_comb begin
        state_nxt = state;
        o_bit_rdy = 1'b0;
        o_busy    = 1'b1;
        case (state)
            COLLECT: begin
                o_bit_rdy = 1'b1;
                o_busy    = 1'b0;
                if (accept && bit_cnt == 3'd7) state_nxt = CALC;
            end
            CALC:    if (row == 2'd3) state_nxt = OUT;
            OUT:     if (take) state_nxt = COLLECT;
            default: state_nxt = COLLECT;
        endcase
    end

    // Row i sums r_ij*x_j for j>=i; entry (i,j) lives at k = j(j+1)/2 + i.
    // x is +-1 per component, so each product is a pair of conditional negations.
    always_comb begin
        row_re = '0;
        row_im = '0;
        ra     = '0;
        rb     = '0;
        a      = '0;
        b      = '0;
        k      = 0;
        for (int unsigned j = 0; j < 4; j++) begin
            if (j >= 32'(row)) begin
                k      = (j * (j + 1)) / 2 + 32'(row);
                ra     = r_reg[k*2*R_W +: R_W];
                rb     = r_reg[k*2*R_W + R_W +: R_W];
                a      = Y_W'(ra);
                b      = Y_W'(rb);
                row_re = row_re + (bits[2*j] ? -a : a) - (bits[2*j+1] ? -b : b);
                row_im = row_im + (bits[2*j+1] ? -a : a) + (bits[2*j] ? -b : b);
            end
        end
    end

`ifdef MOD_NOISE_EN
    logic [15:0]       lfsr;
    logic signed [3:0] n_re, n_im;

    assign n_re = lfsr[3:0];
    assign n_im = lfsr[7:4];
    assign y_re = row_re + Y_W'(n_re);
    assign y_im = row_im + Y_W'(n_im);

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            lfsr <= 16'hACE1;
        end else if (state == CALC) begin
            lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
        end
    end
`else
    assign y_re = row_re;
    assign y_im = row_im;
`endif

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= COLLECT;
            bit_cnt <= '0;
            bits    <= '0;
            r_reg   <= '0;
            row     <= '0;
            vld     <= 1'b0;
            o_y_hat <= '0;
        end else begin
            state <= state_nxt;
            if (i_r_load && state != CALC) r_reg <= i_r;
            if (accept) begin
                bits[bit_cnt] <= i_bit;
                bit_cnt       <= bit_cnt + 3'd1;
            end
            if (state == CALC) begin
                o_y_hat[32'(row)*2*Y_W +: 2*Y_W] <= {y_im, y_re};
                row <= row + 2'd1;
            end
            // o_vld rises one cycle after entering OUT, giving the 4+1 cycle latency.
            if (take) begin
                vld <= 1'b0;
            end else if (state == OUT) begin
                vld <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_qpsk_mimo_modulator.sv
// Scoreboard bench for qpsk_mimo_modulator: directed vectors, hand-computed y_hat, queue-based monitor.
`timescale 1ns/1ps
module tb_qpsk_mimo_modulator;

    localparam int R_W = 16;
    localparam int Y_W = 20;

    logic              i_clk = 1'b0;
    logic              i_reset_n;
    logic              i_r_load;
    logic [20*R_W-1:0] i_r;
    logic              i_bit_vld;
    logic              i_bit;
    logic              o_bit_rdy;
    logic              o_vld;
    logic              i_rdy;
    logic [8*Y_W-1:0]  o_y_hat;
    logic              o_busy;

    int n_cmp = 0;
    int n_bad = 0;
    int vec_id = 0;
    logic [8*Y_W-1:0]  exp_q[$];
    logic [8*Y_W-1:0]  e_mon;
    logic [20*R_W-1:0] r_vec;
    bit                seen = 1'b0;

    always #5 i_clk = ~i_clk;

    qpsk_mimo_modulator #(.R_W(R_W), .Y_W(Y_W)) dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_r_load  (i_r_load),
        .i_r       (i_r),
        .i_bit_vld (i_bit_vld),
        .i_bit     (i_bit),
        .o_bit_rdy (o_bit_rdy),
        .o_vld     (o_vld),
        .i_rdy     (i_rdy),
        .o_y_hat   (o_y_hat),
        .o_busy    (o_busy)
    );

    task automatic chk_i(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_bad++;
            $display("FAIL %s: got %0d required %0d", name, act, req);
        end
    endtask

    task automatic chk_y(input string name, input logic [2*Y_W-1:0] act, input logic [2*Y_W-1:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got (%0d,%0d) required (%0d,%0d)", name,
                     $signed(act[Y_W-1:0]), $signed(act[2*Y_W-1:Y_W]),
                     $signed(req[Y_W-1:0]), $signed(req[2*Y_W-1:Y_W]));
        end
    endtask

    function automatic logic [8*Y_W-1:0] yv(input int r0, input int i0, input int r1, input int i1,
                                            input int r2, input int i2, input int r3, input int i3);
        logic [8*Y_W-1:0] v;
        int a[8];
        a = '{r0, i0, r1, i1, r2, i2, r3, i3};
        for (int n = 0; n < 8; n++) v[n*Y_W +: Y_W] = a[n][Y_W-1:0];
        return v;
    endfunction

    task automatic set_r(input int idx, input int re, input int im);
        r_vec[idx*2*R_W +: 2*R_W] = {im[R_W-1:0], re[R_W-1:0]};
    endtask

    task automatic load_r();
        i_r      = r_vec;
        i_r_load = 1'b1;
        @(negedge i_clk);
        i_r_load = 1'b0;
    endtask

    task automatic load_diag();
        r_vec = '0;
        set_r(0, 100, 0);
        set_r(2, 100, 0);
        set_r(5, 100, 0);
        set_r(9, 100, 0);
        load_r();
    endtask

    // Called at a negedge; returns at the negedge just after the 8th accept edge T.
    task automatic send_bits(input logic [7:0] bv, input bit check_lat);
        for (int i = 0; i < 8; i++) begin
            int w = 0;
            while (!o_bit_rdy && w < 200) begin
                @(negedge i_clk);
                w++;
            end
            if (w >= 200) chk_i("bit_rdy_timeout", 0, 1);
            i_bit_vld = 1'b1;
            i_bit     = bv[i];
            @(negedge i_clk);
        end
        i_bit_vld = 1'b0;
        i_bit     = 1'b0;
        if (check_lat) begin
            repeat (4) @(negedge i_clk);
            chk_i("lat_vld_low_T4", int'(o_vld), 0);
            @(negedge i_clk);
            chk_i("lat_vld_high_T5", int'(o_vld), 1);
        end
    endtask

    task automatic wait_idle();
        int w = 0;
        while ((o_busy || o_vld) && w < 200) begin
            @(negedge i_clk);
            w++;
        end
        if (w >= 200) chk_i("idle_timeout", 0, 1);
    endtask

    always @(negedge i_clk) begin
        if (!i_reset_n) begin
            seen = 1'b0;
        end else if (o_vld && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                chk_i("unexpected_vld", 1, 0);
            end else begin
                e_mon = exp_q.pop_front();
                vec_id++;
                for (int j = 0; j < 4; j++)
                    chk_y($sformatf("vec%0d_y%0d", vec_id, j + 1),
                          o_y_hat[j*2*Y_W +: 2*Y_W], e_mon[j*2*Y_W +: 2*Y_W]);
            end
        end else if (!o_vld) begin
            seen = 1'b0;
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: got no finish required finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [8*Y_W-1:0] e_bp;
        bit stable;
        int w;

        i_reset_n = 1'b0;
        i_r_load  = 1'b0;
        i_r       = '0;
        i_bit_vld = 1'b0;
        i_bit     = 1'b0;
        i_rdy     = 1'b1;
        r_vec     = '0;
        repeat (3) @(negedge i_clk);
        chk_i("rst_vld", int'(o_vld), 0);
        chk_i("rst_busy", int'(o_busy), 0);
        for (int j = 0; j < 4; j++) chk_y("rst_y", o_y_hat[j*2*Y_W +: 2*Y_W], '0);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        chk_i("rst_bit_rdy", int'(o_bit_rdy), 1);

        load_diag();
        exp_q.push_back(yv(100, 100, 100, 100, 100, 100, 100, 100));
        send_bits(8'h00, 1'b1);
        wait_idle();

        exp_q.push_back(yv(-100, -100, -100, -100, -100, -100, -100, -100));
        send_bits(8'hFF, 1'b0);
        wait_idle();

        exp_q.push_back(yv(-100, 100, 100, 100, 100, 100, 100, 100));
        send_bits(8'h01, 1'b0);
        wait_idle();

        exp_q.push_back(yv(-100, 100, -100, 100, 100, -100, 100, -100));
        send_bits(8'hA5, 1'b0);
        wait_idle();

        r_vec = '0;
        set_r(0, 100, 0);
        set_r(1, 0, 50);
        load_r();
        exp_q.push_back(yv(50, 150, 0, 0, 0, 0, 0, 0));
        send_bits(8'h00, 1'b0);
        wait_idle();

        for (int n = 0; n < 10; n++) set_r(n, 32767, -32768);
        load_r();
        exp_q.push_back(yv(262140, -4, 196605, -3, 131070, -2, 65535, -1));
        send_bits(8'h00, 1'b1);
        wait_idle();

        // Backpressure: result must hold and offered bits must not be consumed.
        load_diag();
        i_rdy = 1'b0;
        e_bp  = yv(100, -100, 100, -100, -100, 100, -100, 100);
        exp_q.push_back(e_bp);
        send_bits(8'h5A, 1'b0);
        w = 0;
        while (!o_vld && w < 50) begin
            @(negedge i_clk);
            w++;
        end
        chk_i("bp_vld_rise", int'(o_vld), 1);
        stable    = 1'b1;
        i_bit_vld = 1'b1;
        i_bit     = 1'b1;
        repeat (20) begin
            @(negedge i_clk);
            if (!(o_vld === 1'b1 && o_y_hat === e_bp && o_bit_rdy === 1'b0)) stable = 1'b0;
        end
        chk_i("bp_stable", int'(stable), 1);
        i_bit_vld = 1'b0;
        i_bit     = 1'b0;
        i_rdy     = 1'b1;
        @(negedge i_clk);
        i_rdy = 1'b0;
        chk_i("bp_release_vld", int'(o_vld), 0);
        chk_i("bp_release_bit_rdy", int'(o_bit_rdy), 1);
        for (int j = 0; j < 4; j++) chk_y("bp_hold_y", o_y_hat[j*2*Y_W +: 2*Y_W], e_bp[j*2*Y_W +: 2*Y_W]);
        i_rdy = 1'b1;
        exp_q.push_back(yv(100, 100, 100, 100, 100, 100, 100, 100));
        send_bits(8'h00, 1'b0);
        wait_idle();

        // Reset during the second CALC cycle discards the vector in flight.
        send_bits(8'hFF, 1'b0);
        @(negedge i_clk);
        i_reset_n = 1'b0;
        #1;
        chk_i("midrst_vld", int'(o_vld), 0);
        chk_i("midrst_busy", int'(o_busy), 0);
        for (int j = 0; j < 4; j++) chk_y("midrst_y", o_y_hat[j*2*Y_W +: 2*Y_W], '0);
        repeat (2) @(negedge i_clk);
        i_reset_n = 1'b1;
        @(negedge i_clk);
        load_diag();
        exp_q.push_back(yv(-100, -100, -100, -100, 100, 100, 100, 100));
        send_bits(8'h0F, 1'b1);
        wait_idle();

        repeat (3) @(negedge i_clk);
        chk_i("sb_drain", exp_q.size(), 0);
        chk_i("vec_count", vec_id, 9);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
